frame_buffer_manager: RTL and testbench

FRAME_BUFFER_MANAGER -- requirements
Module: frame_buffer_manager

---
 rtl/frame_buffer_manager.sv | 145 ++++++++++++++
 tb/tb_frame_buffer_manager.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_manager.sv
// frame_buffer_manager: rotating pool of frame buffers between a
// renderer (writer) and a display (reader), with show/drop statistics.
module frame_buffer_manager #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 76800,
    parameter int ADDR_LEN = 17,
    parameter int NUM_BUFS = 3,
    parameter int CNT_BITS = 16
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                write_enable_in,
    input  logic [ADDR_LEN-1:0] write_addr_in,
    input  logic [WIDTH-1:0]    write_data_in,
    input  logic                write_frame_done_in,
    input  logic [ADDR_LEN-1:0] read_addr_in,
    input  logic                read_frame_start_in,
    output logic [WIDTH-1:0]    read_data_out,
    output logic [1:0]          write_buf_out,
    output logic [1:0]          read_buf_out,
    output logic                write_stall_out,
    output logic [CNT_BITS-1:0] frames_shown_out,
    output logic [CNT_BITS-1:0] frames_dropped_out
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = $clog2(NUM_BUFS);
    localparam logic [ADDR_LEN:0] DEPTH_L = DEPTH[ADDR_LEN:0];

    logic [WIDTH-1:0] mem [NUM_BUFS][DEPTH];

    // Buffer roles are held as indices; any buffer that is neither
    // displaying, ready nor writing is implicitly free.
    logic [1:0] disp_q, disp_n;
    logic [1:0] wr_q, wr_n;
    logic [1:0] rdy_q, rdy_n;
    logic       wr_v_q, wr_v_n;
    logic       rdy_v_q, rdy_v_n;

    logic [CNT_BITS-1:0] shown_q;
    logic [CNT_BITS-1:0] dropped_q;

    logic       drop;
    logic       shown;
    logic       free_ok;
    logic [1:0] free_idx;

    logic wr_ok;
    logic rd_ok;

    assign wr_ok = ({1'b0, write_addr_in} < DEPTH_L);
    assign rd_ok = ({1'b0, read_addr_in} < DEPTH_L);

    // Next roles: retire the writer, then promote, then refill writer.
    always_comb begin
        disp_n   = disp_q;
        wr_n     = wr_q;
        wr_v_n   = wr_v_q;
        rdy_n    = rdy_q;
        rdy_v_n  = rdy_v_q;
        drop     = 1'b0;
        shown    = 1'b0;
        free_ok  = 1'b0;
        free_idx = 2'd0;
        if (write_frame_done_in && wr_v_q) begin
            drop    = rdy_v_q;
            rdy_n   = wr_q;
            rdy_v_n = 1'b1;
            wr_v_n  = 1'b0;
        end
        if (read_frame_start_in && rdy_v_n) begin
            disp_n  = rdy_n;
            rdy_v_n = 1'b0;
            shown   = 1'b1;
        end
        for (int i = NUM_BUFS - 1; i >= 0; i--) begin
            if (2'(i) != disp_n &&
                !(rdy_v_n && 2'(i) == rdy_n)) begin
                free_ok  = 1'b1;
                free_idx = 2'(i);
            end
        end
        if (!wr_v_n && free_ok) begin
            wr_n   = free_idx;
            wr_v_n = 1'b1;
        end
    end

    // Role registers; wr_q keeps its last value while stalled.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            disp_q  <= 2'd0;
            wr_q    <= 2'd1;
            wr_v_q  <= 1'b1;
            rdy_q   <= 2'd0;
            rdy_v_q <= 1'b0;
        end else begin
            disp_q  <= disp_n;
            wr_q    <= wr_n;
            wr_v_q  <= wr_v_n;
            rdy_q   <= rdy_n;
            rdy_v_q <= rdy_v_n;
        end
    end

    // Saturating frame statistics.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            shown_q   <= '0;
            dropped_q <= '0;
        end else begin
            if (shown && shown_q != '1) begin
                shown_q <= shown_q + 1'b1;
            end
            if (drop && dropped_q != '1) begin
                dropped_q <= dropped_q + 1'b1;
            end
        end
    end

    // Pixel write into the buffer that was writing before this edge.
    always_ff @(posedge clk_in) begin
        if (write_enable_in && wr_v_q && wr_ok) begin
            mem[wr_q[BW-1:0]][write_addr_in[AW-1:0]] <= write_data_in;
        end
    end

    // Registered pixel read from the currently displayed buffer.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            read_data_out <= '0;
        end else if (rd_ok) begin
            read_data_out <= mem[disp_q[BW-1:0]][read_addr_in[AW-1:0]];
        end else begin
            read_data_out <= '0;
        end
    end

    assign write_buf_out      = wr_q;
    assign read_buf_out       = disp_q;
    assign write_stall_out    = ~wr_v_q;
    assign frames_shown_out   = shown_q;
    assign frames_dropped_out = dropped_q;

endmodule

// File: tb/tb_frame_buffer_manager.sv
// tb_frame_buffer_manager: 3-buffer and 2-buffer instances driven
// together and checked against a tag-based behavioural model.
module tb_frame_buffer_manager;

    localparam int D    = 16;
    localparam int CMAX = 15;
    localparam int FREE = 0;
    localparam int WRG  = 1;
    localparam int RDY  = 2;
    localparam int DSP  = 3;

    logic       clk;
    logic       rst_n;
    logic       we_i;
    logic [4:0] wa_i;
    logic [3:0] wd_i;
    logic       fd_i;
    logic [4:0] ra_i;
    logic       fs_i;

    logic [3:0] rd_o [2];
    logic [1:0] wb_o [2];
    logic [1:0] rb_o [2];
    logic       st_o [2];
    logic [3:0] sh_o [2];
    logic [3:0] dr_o [2];

    int vec;
    int errs;
    bit chk_on;

    int tag [2][4];
    int mm [2][4][D];
    int m_rd [2];
    int m_sh [2];
    int m_dr [2];
    int m_wb [2];

    frame_buffer_manager #(
        .WIDTH(4), .DEPTH(D), .ADDR_LEN(5),
        .NUM_BUFS(3), .CNT_BITS(4)
    ) u3 (
        .clk_in(clk), .rst_in(rst_n),
        .write_enable_in(we_i), .write_addr_in(wa_i),
        .write_data_in(wd_i), .write_frame_done_in(fd_i),
        .read_addr_in(ra_i), .read_frame_start_in(fs_i),
        .read_data_out(rd_o[0]), .write_buf_out(wb_o[0]),
        .read_buf_out(rb_o[0]), .write_stall_out(st_o[0]),
        .frames_shown_out(sh_o[0]),
        .frames_dropped_out(dr_o[0])
    );

    frame_buffer_manager #(
        .WIDTH(4), .DEPTH(D), .ADDR_LEN(5),
        .NUM_BUFS(2), .CNT_BITS(4)
    ) u2 (
        .clk_in(clk), .rst_in(rst_n),
        .write_enable_in(we_i), .write_addr_in(wa_i),
        .write_data_in(wd_i), .write_frame_done_in(fd_i),
        .read_addr_in(ra_i), .read_frame_start_in(fs_i),
        .read_data_out(rd_o[1]), .write_buf_out(wb_o[1]),
        .read_buf_out(rb_o[1]), .write_stall_out(st_o[1]),
        .frames_shown_out(sh_o[1]),
        .frames_dropped_out(dr_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nb(input int k);
        return (k == 0) ? 3 : 2;
    endfunction

    function automatic int find(input int k, input int t);
        for (int i = 0; i < nb(k); i++) begin
            if (tag[k][i] == t) return i;
        end
        return -1;
    endfunction

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        vec++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic model_step();
        int d, w, r, f;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) tag[k][i] = FREE;
                tag[k][0] = DSP;
                tag[k][1] = WRG;
                m_rd[k] = 0;
                m_sh[k] = 0;
                m_dr[k] = 0;
                m_wb[k] = 1;
            end else begin
                d = find(k, DSP);
                w = find(k, WRG);
                if (int'(ra_i) < D) m_rd[k] = mm[k][d][ra_i];
                else m_rd[k] = 0;
                if (we_i && w >= 0 && int'(wa_i) < D)
                    mm[k][w][wa_i] = int'(wd_i);
                if (fd_i && w >= 0) begin
                    r = find(k, RDY);
                    if (r >= 0) begin
                        tag[k][r] = FREE;
                        m_dr[k] = sat(m_dr[k]);
                    end
                    tag[k][w] = RDY;
                end
                r = find(k, RDY);
                if (fs_i && r >= 0) begin
                    tag[k][d] = FREE;
                    tag[k][r] = DSP;
                    m_sh[k] = sat(m_sh[k]);
                end
                if (find(k, WRG) < 0) begin
                    f = find(k, FREE);
                    if (f >= 0) begin
                        tag[k][f] = WRG;
                        m_wb[k] = f;
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                for (int k = 0; k < 2; k++) begin
                    if (m_rd[k] >= 0)
                        chk($sformatf("rd%0d", k),
                            int'(rd_o[k]), m_rd[k]);
                    chk($sformatf("wb%0d", k),
                        int'(wb_o[k]), m_wb[k]);
                    chk($sformatf("rb%0d", k),
                        int'(rb_o[k]), find(k, DSP));
                    chk($sformatf("st%0d", k),
                        int'(st_o[k]), int'(find(k, WRG) < 0));
                    chk($sformatf("sh%0d", k),
                        int'(sh_o[k]), m_sh[k]);
                    chk($sformatf("dr%0d", k),
                        int'(dr_o[k]), m_dr[k]);
                end
            end
        end
    end

    task automatic step(input int we, input int wa, input int wd,
                        input int fd, input int fs, input int ra);
        we_i = we[0];
        wa_i = wa[4:0];
        wd_i = wd[3:0];
        fd_i = fd[0];
        fs_i = fs[0];
        ra_i = ra[4:0];
        @(negedge clk);
    endtask

    task automatic idle();
        we_i = 1'b0;
        fd_i = 1'b0;
        fs_i = 1'b0;
        wa_i = 5'd0;
        wd_i = 4'd0;
        ra_i = 5'd16;
    endtask

    task automatic do_reset(input bit lits);
        idle();
        #2 rst_n = 1'b0;
        #1;
        if (lits) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rst_wb%0d", k), int'(wb_o[k]), 1);
                chk($sformatf("rst_rb%0d", k), int'(rb_o[k]), 0);
                chk($sformatf("rst_st%0d", k), int'(st_o[k]), 0);
                chk($sformatf("rst_rd%0d", k), int'(rd_o[k]), 0);
                chk($sformatf("rst_dr%0d", k), int'(dr_o[k]), 0);
            end
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        vec    = 0;
        errs   = 0;
        chk_on = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int b = 0; b < 4; b++)
                for (int a = 0; a < D; a++)
                    mm[k][b][a] = -1;
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("init_wb%0d", k), int'(wb_o[k]), 1);
            chk($sformatf("init_rb%0d", k), int'(rb_o[k]), 0);
            chk($sformatf("init_st%0d", k), int'(st_o[k]), 0);
            chk($sformatf("init_sh%0d", k), int'(sh_o[k]), 0);
            chk($sformatf("init_rd%0d", k), int'(rd_o[k]), 0);
        end
        chk_on = 1'b1;

        step(1, 5, 'hA, 0, 0, 16);
        step(0, 0, 0, 1, 0, 16);
        chk("s2_st3", int'(st_o[0]), 0);
        chk("s2_st2", int'(st_o[1]), 1);
        chk("s2_wb3", int'(wb_o[0]), 2);
        chk("s2_wb2_hold", int'(wb_o[1]), 1);
        step(0, 0, 0, 0, 1, 16);
        step(0, 0, 0, 0, 0, 5);
        chk("s4_rd3", int'(rd_o[0]), 'hA);
        chk("s4_rd2", int'(rd_o[1]), 'hA);
        chk("s4_rb3", int'(rb_o[0]), 1);
        chk("s4_sh3", int'(sh_o[0]), 1);
        chk("s4_wb2", int'(wb_o[1]), 0);
        chk("s4_st2", int'(st_o[1]), 0);
        step(1, 3, 6, 0, 0, 16);
        do_reset(1'b1);

        step(0, 0, 0, 1, 1, 16);
        chk("sim_rb3", int'(rb_o[0]), 1);
        chk("sim_wb3", int'(wb_o[0]), 0);
        chk("sim_rb2", int'(rb_o[1]), 1);
        chk("sim_wb2", int'(wb_o[1]), 0);
        chk("sim_sh3", int'(sh_o[0]), 1);
        chk("sim_st2", int'(st_o[1]), 0);
        step(0, 0, 0, 1, 0, 16);
        step(0, 0, 0, 1, 0, 16);
        chk("dd_dr3", int'(dr_o[0]), 1);
        chk("dd_wb3", int'(wb_o[0]), 0);
        chk("dd_st3", int'(st_o[0]), 0);
        chk("dd_st2", int'(st_o[1]), 1);
        chk("dd_dr2", int'(dr_o[1]), 0);
        step(1, 3, 'hF, 0, 0, 16);
        chk("stw_st2", int'(st_o[1]), 1);
        step(0, 0, 0, 0, 1, 16);
        chk("unst_st2", int'(st_o[1]), 0);
        chk("unst_wb2", int'(wb_o[1]), 1);
        chk("unst_sh2", int'(sh_o[1]), 2);
        step(0, 0, 0, 0, 0, 3);
        chk("keep_rd2", int'(rd_o[1]), 6);
        chk("keep_rd3", int'(rd_o[0]), 6);
        step(0, 0, 0, 1, 0, 16);
        chk("pre_rst_st2", int'(st_o[1]), 1);
        do_reset(1'b1);
        step(0, 0, 0, 0, 0, 3);
        chk("ret_rd2", int'(rd_o[1]), 6);
        chk("ret_rd3", int'(rd_o[0]), 'hF);

        step(1, 0, 3, 0, 0, 16);
        step(1, 16, 9, 0, 0, 16);
        step(0, 0, 0, 1, 1, 16);
        step(0, 0, 0, 0, 0, 0);
        chk("oob_rd3_a0", int'(rd_o[0]), 3);
        chk("oob_rd2_a0", int'(rd_o[1]), 3);
        step(0, 0, 0, 0, 0, 16);
        chk("oob_rd3", int'(rd_o[0]), 0);
        chk("oob_rd2", int'(rd_o[1]), 0);

        repeat (20) step(0, 0, 0, 1, 0, 16);
        chk("sat_dr3", int'(dr_o[0]), 15);
        chk("sat_dr2", int'(dr_o[1]), 0);
        repeat (18) step(0, 0, 0, 1, 1, 16);
        chk("sat_sh3", int'(sh_o[0]), 15);
        chk("sat_sh2", int'(sh_o[1]), 15);
        do_reset(1'b0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(1'b0);
            end else begin
                step(int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 20)),
                     int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 5) == 0),
                     int'($urandom_range(0, 5) == 0),
                     int'($urandom_range(0, 20)));
            end
        end
        idle();
        @(negedge clk);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vec, errs);
        $finish;
    end

endmodule
